// File: rtl/mem_arbiter_if.sv
// Bundle of the I-cache, D-cache and memory-side signals of the memory arbiter.
// The slave modport is the arbiter's view; the master modport is the caches'/memory's view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
);
  logic              ic_mem_read;
  logic [ADDR_W-1:0] ic_mem_addr;
  logic [DATA_W-1:0] ic_mem_rdata;
  logic              ic_mem_ready;

  logic              dc_mem_read;
  logic              dc_mem_write;
  logic [ADDR_W-1:0] dc_mem_addr;
  logic [DATA_W-1:0] dc_mem_wdata;
  logic [DATA_W-1:0] dc_mem_rdata;
  logic              dc_mem_ready;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  logic              arb_busy;

  // Handshake: a cache raises its read/write request and holds it, with address/data
  // stable, until its *_mem_ready pulses for one cycle; memory completes the granted
  // transfer by pulsing mem_ready while mem_read or mem_write is high.
  modport slave (
    input  ic_mem_read, ic_mem_addr,
    input  dc_mem_read, dc_mem_write, dc_mem_addr, dc_mem_wdata,
    input  mem_rdata, mem_ready,
    output ic_mem_rdata, ic_mem_ready,
    output dc_mem_rdata, dc_mem_ready,
    output mem_read, mem_write, mem_addr, mem_wdata,
    output arb_busy
  );

  modport master (
    output ic_mem_read, ic_mem_addr,
    output dc_mem_read, dc_mem_write, dc_mem_addr, dc_mem_wdata,
    output mem_rdata, mem_ready,
    input  ic_mem_rdata, ic_mem_ready,
    input  dc_mem_rdata, dc_mem_ready,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    input  arb_busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (I-cache / D-cache) round-robin arbiter in front of a single line-wide memory port.
// A grant is registered, held for one whole transfer, and followed by a one-cycle DONE bubble.
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic       clk,
  input  logic       proc_reset,
  mem_arbiter_if.slave bus,
  output logic [1:0] state_dbg,
  output logic       last_grant_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic LG_I = 1'b0;
  localparam logic LG_D = 1'b1;

  state_t state;
  state_t arb_next;
  logic   last_grant;
  logic   ic_req;
  logic   dc_req;

  assign ic_req = bus.ic_mem_read;
  assign dc_req = bus.dc_mem_read | bus.dc_mem_write;

  // On a tie the requester that was not served last wins; reset leaves last_grant at I,
  // so the first tie goes to D.
  always_comb begin
    arb_next = IDLE;
    if (ic_req && dc_req) begin
      arb_next = (last_grant == LG_I) ? GRANT_D : GRANT_I;
    end else if (ic_req) begin
      arb_next = GRANT_I;
    end else if (dc_req) begin
      arb_next = GRANT_D;
    end
  end

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state      <= IDLE;
      last_grant <= LG_I;
    end else begin
      case (state)
        IDLE, DONE: state <= arb_next;
        GRANT_I: begin
          if (bus.mem_ready) begin
            state      <= DONE;
            last_grant <= LG_I;
          end else if (!ic_req) begin
            state <= IDLE;
          end
        end
        GRANT_D: begin
          if (bus.mem_ready) begin
            state      <= DONE;
            last_grant <= LG_D;
          end else if (!dc_req) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory strobes follow the granted requester combinationally so a dropped request
  // or an asynchronous reset removes them within the same cycle.
  always_comb begin
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = {ADDR_W{1'b0}};
    bus.mem_wdata = {DATA_W{1'b0}};
    case (state)
      GRANT_I: begin
        bus.mem_read = bus.ic_mem_read;
        bus.mem_addr = bus.ic_mem_addr;
      end
      GRANT_D: begin
        bus.mem_write = bus.dc_mem_write;
        bus.mem_read  = bus.dc_mem_read & ~bus.dc_mem_write;
        bus.mem_addr  = bus.dc_mem_addr;
        bus.mem_wdata = bus.dc_mem_wdata;
      end
      default: ;
    endcase
  end

  assign bus.ic_mem_ready = bus.mem_ready & (state == GRANT_I);
  assign bus.dc_mem_ready = bus.mem_ready & (state == GRANT_D);
  assign bus.ic_mem_rdata = bus.mem_rdata;
  assign bus.dc_mem_rdata = bus.mem_rdata;
  assign bus.arb_busy     = (state != IDLE);

  assign state_dbg      = state;
  assign last_grant_dbg = last_grant;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: lone fill, tie after reset, write-back/fill round-robin,
// spurious ready, reset mid-transfer and request drop.
module tb_mem_arbiter;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_GI   = 2'd1;
  localparam logic [1:0] S_GD   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic       clk;
  logic       proc_reset;
  logic [1:0] state_dbg;
  logic       last_grant_dbg;

  int checks = 0;
  int errors = 0;

  mem_arbiter_if #(.ADDR_W(28), .DATA_W(128)) bus ();

  mem_arbiter #(.ADDR_W(28), .DATA_W(128)) dut (
    .clk            (clk),
    .proc_reset     (proc_reset),
    .bus            (bus),
    .state_dbg      (state_dbg),
    .last_grant_dbg (last_grant_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.ic_mem_read  = 1'b0;
    bus.ic_mem_addr  = '0;
    bus.dc_mem_read  = 1'b0;
    bus.dc_mem_write = 1'b0;
    bus.dc_mem_addr  = '0;
    bus.dc_mem_wdata = '0;
    bus.mem_rdata    = '0;
    bus.mem_ready    = 1'b0;
  endtask

  // scoreboard check
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  localparam logic [127:0] RDATA_A = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0000_F625;
  localparam logic [127:0] RDATA_B = 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA;
  localparam logic [127:0] WDATA_A = 128'h1111_1111_1111_1111_1111_1111_1111_1111;

  initial begin
    idle_inputs();
    proc_reset = 1'b1;
    settle();
    check("rst_state", state_dbg, S_IDLE);
    check("rst_busy", bus.arb_busy, 1'b0);
    check("rst_rd", bus.mem_read, 1'b0);
    check("rst_wr", bus.mem_write, 1'b0);
    check("rst_addr", bus.mem_addr, 28'h0);
    check("rst_lg", last_grant_dbg, 1'b0);
    cyc();
    cyc();
    proc_reset = 1'b0;

    // Lone I-fill
    cyc();
    bus.ic_mem_read = 1'b1;
    bus.ic_mem_addr = 28'h0000010;
    settle();
    check("i_c0_rd", bus.mem_read, 1'b0);
    check("i_c0_busy", bus.arb_busy, 1'b0);
    cyc();
    check("i_c1_state", state_dbg, S_GI);
    check("i_c1_rd", bus.mem_read, 1'b1);
    check("i_c1_wr", bus.mem_write, 1'b0);
    check("i_c1_addr", bus.mem_addr, 28'h0000010);
    check("i_c1_busy", bus.arb_busy, 1'b1);
    cyc();
    check("i_c2_rd", bus.mem_read, 1'b1);
    cyc();
    check("i_c3_addr", bus.mem_addr, 28'h0000010);
    cyc();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = RDATA_A;
    settle();
    check("i_c4_rd", bus.mem_read, 1'b1);
    check("i_c4_iready", bus.ic_mem_ready, 1'b1);
    check("i_c4_irdata", bus.ic_mem_rdata, RDATA_A);
    check("i_c4_drdata", bus.dc_mem_rdata, RDATA_A);
    check("i_c4_dready", bus.dc_mem_ready, 1'b0);
    cyc();
    bus.mem_ready   = 1'b0;
    bus.ic_mem_read = 1'b0;
    settle();
    check("i_c5_state", state_dbg, S_DONE);
    check("i_c5_rd", bus.mem_read, 1'b0);
    check("i_c5_addr", bus.mem_addr, 28'h0);
    check("i_c5_busy", bus.arb_busy, 1'b1);
    check("i_c5_lg", last_grant_dbg, 1'b0);
    cyc();
    check("i_c6_state", state_dbg, S_IDLE);

    // Simultaneous requests after reset
    proc_reset = 1'b1;
    settle();
    cyc();
    proc_reset = 1'b0;
    bus.ic_mem_read = 1'b1;
    bus.ic_mem_addr = 28'h0000040;
    bus.dc_mem_read = 1'b1;
    bus.dc_mem_addr = 28'h0000050;
    cyc();
    check("s_c1_state", state_dbg, S_GD);
    check("s_c1_addr", bus.mem_addr, 28'h0000050);
    check("s_c1_rd", bus.mem_read, 1'b1);
    cyc();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = RDATA_B;
    settle();
    check("s_c2_dready", bus.dc_mem_ready, 1'b1);
    check("s_c2_iready", bus.ic_mem_ready, 1'b0);
    check("s_c2_drdata", bus.dc_mem_rdata, RDATA_B);
    cyc();
    bus.mem_ready   = 1'b0;
    bus.dc_mem_read = 1'b0;
    settle();
    check("s_c3_state", state_dbg, S_DONE);
    check("s_c3_rd", bus.mem_read, 1'b0);
    check("s_c3_lg", last_grant_dbg, 1'b1);
    cyc();
    check("s_c4_state", state_dbg, S_GI);
    check("s_c4_addr", bus.mem_addr, 28'h0000040);
    bus.mem_ready = 1'b1;
    settle();
    check("s_c4_iready", bus.ic_mem_ready, 1'b1);
    cyc();
    bus.mem_ready   = 1'b0;
    bus.ic_mem_read = 1'b0;
    cyc();
    check("s_c6_state", state_dbg, S_IDLE);

    // Write-back then fill with a held I-fill
    bus.dc_mem_write = 1'b1;
    bus.dc_mem_addr  = 28'h0000020;
    bus.dc_mem_wdata = WDATA_A;
    cyc();
    bus.ic_mem_read = 1'b1;
    bus.ic_mem_addr = 28'h0000060;
    settle();
    check("w_c1_state", state_dbg, S_GD);
    check("w_c1_wr", bus.mem_write, 1'b1);
    check("w_c1_rd", bus.mem_read, 1'b0);
    check("w_c1_addr", bus.mem_addr, 28'h0000020);
    check("w_c1_wdata", bus.mem_wdata, WDATA_A);
    cyc();
    check("w_c2_noprempt", state_dbg, S_GD);
    bus.mem_ready = 1'b1;
    settle();
    check("w_c2_dready", bus.dc_mem_ready, 1'b1);
    cyc();
    bus.mem_ready    = 1'b0;
    bus.dc_mem_write = 1'b0;
    bus.dc_mem_read  = 1'b1;
    bus.dc_mem_addr  = 28'h0000030;
    settle();
    check("w_c3_state", state_dbg, S_DONE);
    check("w_c3_wr", bus.mem_write, 1'b0);
    check("w_c3_rd", bus.mem_read, 1'b0);
    cyc();
    check("w_c4_state", state_dbg, S_GI);
    check("w_c4_addr", bus.mem_addr, 28'h0000060);
    bus.mem_ready = 1'b1;
    settle();
    check("w_c4_iready", bus.ic_mem_ready, 1'b1);
    cyc();
    bus.mem_ready   = 1'b0;
    bus.ic_mem_read = 1'b0;
    cyc();
    check("w_c6_state", state_dbg, S_GD);
    check("w_c6_rd", bus.mem_read, 1'b1);
    check("w_c6_addr", bus.mem_addr, 28'h0000030);
    bus.dc_mem_write = 1'b1;
    settle();
    check("w_c6_wrwins_wr", bus.mem_write, 1'b1);
    check("w_c6_wrwins_rd", bus.mem_read, 1'b0);
    bus.dc_mem_write = 1'b0;
    bus.mem_ready    = 1'b1;
    settle();
    check("w_c6_dready", bus.dc_mem_ready, 1'b1);
    cyc();
    bus.mem_ready   = 1'b0;
    bus.dc_mem_read = 1'b0;
    cyc();
    check("w_c8_state", state_dbg, S_IDLE);

    // Spurious ready in IDLE
    bus.mem_ready = 1'b1;
    settle();
    check("sp_iready", bus.ic_mem_ready, 1'b0);
    check("sp_dready", bus.dc_mem_ready, 1'b0);
    cyc();
    check("sp_state", state_dbg, S_IDLE);
    bus.mem_ready = 1'b0;

    // Reset mid-transfer
    bus.dc_mem_read = 1'b1;
    bus.dc_mem_addr = 28'h0000070;
    cyc();
    check("r_c1_state", state_dbg, S_GD);
    check("r_c1_rd", bus.mem_read, 1'b1);
    proc_reset    = 1'b1;
    bus.mem_ready = 1'b1;
    settle();
    check("r_rd_drop", bus.mem_read, 1'b0);
    check("r_addr_drop", bus.mem_addr, 28'h0);
    check("r_dready", bus.dc_mem_ready, 1'b0);
    check("r_busy", bus.arb_busy, 1'b0);
    cyc();
    proc_reset      = 1'b0;
    bus.mem_ready   = 1'b0;
    bus.dc_mem_read = 1'b0;
    settle();
    check("r_state", state_dbg, S_IDLE);
    check("r_lg", last_grant_dbg, 1'b0);

    // Request drop: first make last_grant D
    bus.dc_mem_read = 1'b1;
    bus.dc_mem_addr = 28'h0000090;
    cyc();
    bus.mem_ready = 1'b1;
    cyc();
    bus.mem_ready   = 1'b0;
    bus.dc_mem_read = 1'b0;
    cyc();
    check("d_pre_state", state_dbg, S_IDLE);
    check("d_pre_lg", last_grant_dbg, 1'b1);
    bus.ic_mem_read = 1'b1;
    bus.ic_mem_addr = 28'h0000080;
    cyc();
    check("d_c1_state", state_dbg, S_GI);
    cyc();
    bus.ic_mem_read = 1'b0;
    settle();
    check("d_rd_drop", bus.mem_read, 1'b0);
    cyc();
    check("d_state", state_dbg, S_IDLE);
    check("d_lg", last_grant_dbg, 1'b1);
    bus.ic_mem_read = 1'b1;
    bus.dc_mem_read = 1'b1;
    cyc();
    check("d_tie_to_i", state_dbg, S_GI);
    idle_inputs();
    cyc();
    check("d_end_state", state_dbg, S_IDLE);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
